// File: rtl/pmu_csr_if.sv
// pmu_csr_if: CSR write/read bundle feeding the PMU counter window
interface pmu_csr_if;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_re;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_rhit;
  modport master(output csr_we, csr_waddr, csr_wdata, csr_re, csr_raddr, input csr_rdata, csr_rhit);
  modport slave(input csr_we, csr_waddr, csr_wdata, csr_re, csr_raddr, output csr_rdata, csr_rhit);
endinterface

// File: rtl/pmu_counter_bank.sv
// pmu_counter_bank: wide event counters with CSR window and high-word snapshot; overflow STATUS/irq under PMU_OVERFLOW_IRQ_EN
module pmu_counter_bank #(
  parameter int          NUM_EVENTS = 21,
  parameter int          CNT_WIDTH  = 48,
  parameter int          INC_WIDTH  = 2,
  parameter logic [13:0] BASE_ADDR  = 14'h200
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0] event_inc,
  pmu_csr_if.slave                        csr,
  output logic                            pmu_irq
);
  localparam int HW = CNT_WIDTH - 32;
  logic [CNT_WIDTH-1:0]  cnt [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  nxt [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  sum;
  logic [INC_WIDTH-1:0]  inc;
  logic [NUM_EVENTS-1:0] status;
  logic [HW-1:0]         shadow, rd_hi;
  logic [4:0]            sh_idx, rd_idx;
  logic [31:0]           rval;
  logic [13:0]           woff, roff;
  logic                  en, frz, irq_en, sh_vld, rd_lo, rhit, wlo, whi, wctrl, clr;
  assign woff  = csr.csr_waddr - BASE_ADDR;
  assign roff  = csr.csr_raddr - BASE_ADDR;
  assign wctrl = csr.csr_we && woff == 14'h3F;
  assign clr   = wctrl && csr.csr_wdata[2];
`ifdef PMU_OVERFLOW_IRQ_EN
  logic [NUM_EVENTS-1:0] ovf;
  logic                  cy;
`endif
  always_comb begin
`ifdef PMU_OVERFLOW_IRQ_EN
    ovf = '0;
    cy  = 1'b0;
`endif
    sum = '0;
    inc = '0;
    wlo = 1'b0;
    whi = 1'b0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      inc = (en && !frz) ? event_inc[i*INC_WIDTH +: INC_WIDTH] : '0;
`ifdef PMU_OVERFLOW_IRQ_EN
      {cy, sum} = {1'b0, cnt[i]} + (CNT_WIDTH+1)'(inc);
`else
      sum = cnt[i] + CNT_WIDTH'(inc);
`endif
      wlo = csr.csr_we && woff == 14'(i);
      whi = csr.csr_we && woff == 14'(64 + i);
      nxt[i] = clr ? '0 : wlo ? {cnt[i][CNT_WIDTH-1:32], csr.csr_wdata} :
               whi ? {csr.csr_wdata[HW-1:0], cnt[i][31:0]} : sum;
`ifdef PMU_OVERFLOW_IRQ_EN
      ovf[i] = cy && !wlo && !whi && !clr;
`endif
    end
  end
  always_comb begin
    rval   = '0;
    rhit   = 1'b0;
    rd_lo  = 1'b0;
    rd_idx = '0;
    rd_hi  = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (roff == 14'(i)) begin
        rval   = cnt[i][31:0];
        rhit   = 1'b1;
        rd_lo  = 1'b1;
        rd_idx = 5'(i);
        rd_hi  = cnt[i][CNT_WIDTH-1:32];
      end
      if (roff == 14'(64 + i)) begin
        rval = 32'((sh_vld && sh_idx == 5'(i)) ? shadow : cnt[i][CNT_WIDTH-1:32]);
        rhit = 1'b1;
      end
    end
    if (roff == 14'h3E) begin
      rval = 32'(status);
      rhit = 1'b1;
    end
    if (roff == 14'h3F) begin
      rval = {28'd0, irq_en, 1'b0, frz, en};
      rhit = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_EVENTS; i++) cnt[i] <= '0;
      en            <= 1'b1;
      frz           <= 1'b0;
      shadow        <= '0;
      sh_idx        <= '0;
      sh_vld        <= 1'b0;
      csr.csr_rdata <= '0;
      csr.csr_rhit  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) cnt[i] <= nxt[i];
      en  <= wctrl ? csr.csr_wdata[0] : en;
      frz <= wctrl ? csr.csr_wdata[1] : frz;
      if (clr) begin
        shadow <= '0;
        sh_idx <= '0;
        sh_vld <= 1'b0;
      end else if (csr.csr_re && rd_lo) begin
        shadow <= rd_hi;
        sh_idx <= rd_idx;
        sh_vld <= 1'b1;
      end
      if (csr.csr_re) begin
        csr.csr_rdata <= rval;
        csr.csr_rhit  <= rhit;
      end
    end
  end
`ifdef PMU_OVERFLOW_IRQ_EN
  logic wstat;
  assign wstat = csr.csr_we && woff == 14'h3E;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status  <= '0;
      irq_en  <= 1'b0;
      pmu_irq <= 1'b0;
    end else begin
      status  <= clr ? '0 : (status & ~(wstat ? csr.csr_wdata[NUM_EVENTS-1:0] : '0)) | ovf;
      irq_en  <= wctrl ? csr.csr_wdata[3] : irq_en;
      pmu_irq <= irq_en && |status;
    end
  end
`else
  assign status  = '0;
  assign irq_en  = 1'b0;
  assign pmu_irq = 1'b0;
`endif
endmodule

// File: tb/tb_pmu_counter_bank.sv
// tb_pmu_counter_bank: directed plus random checks of pmu_counter_bank against a behavioural model
module tb_pmu_counter_bank;
  localparam int          N  = 21;
  localparam int          W  = 48;
  localparam int          IW = 2;
  localparam logic [13:0] B  = 14'h200;
  localparam logic [63:0] MASK  = (64'd1 << W) - 64'd1;
  localparam logic [31:0] NMASK = (32'd1 << N) - 32'd1;
`ifdef PMU_OVERFLOW_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*IW-1:0] ev = '0;
  logic pmu_irq;
  pmu_csr_if bus();
  pmu_counter_bank #(.NUM_EVENTS(N), .CNT_WIDTH(W), .INC_WIDTH(IW), .BASE_ADDR(B)) dut (
    .clk(clk), .rst_n(rst_n), .event_inc(ev), .csr(bus), .pmu_irq(pmu_irq));
  always #5 clk = ~clk;

  logic [63:0] m [N];
  logic [31:0] st;
  bit          en, frz, ie, shv;
  logic [63:0] sh;
  int          shi;
  logic [31:0] exp_rd;
  bit          exp_hit;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < N; i++) m[i] = 64'd0;
    st = 0; en = 1; frz = 0; ie = 0; shv = 0; sh = 0; shi = 0;
    exp_rd = 0; exp_hit = 0;
  endtask

  function automatic logic [32:0] mrd(logic [13:0] a);
    int o;
    o = int'(14'(a - B));
    if (o < N) return {1'b1, m[o][31:0]};
    if (o >= 64 && o < 64 + N) return {1'b1, (shv && shi == o - 64) ? sh[31:0] : m[o-64][63:32]};
    if (o == 'h3E) return {1'b1, st};
    if (o == 'h3F) return {1'b1, 28'd0, ie, 1'b0, frz, en};
    return 33'd0;
  endfunction

  task automatic cyc(bit we, logic [13:0] wa, logic [31:0] wd, bit re, logic [13:0] ra, logic [N*IW-1:0] inc);
    logic [32:0] r;
    logic [63:0] nm [N];
    logic [63:0] s;
    logic [31:0] ovf;
    logic [13:0] wo;
    int ro;
    bit clr, irq_n;
    bus.csr_we = we; bus.csr_waddr = wa; bus.csr_wdata = wd;
    bus.csr_re = re; bus.csr_raddr = ra; ev = inc;
    r = mrd(ra);
    wo = wa - B;
    ro = int'(14'(ra - B));
    clr = we && wo == 14'h3F && wd[2];
    irq_n = ie && st != 0;
    ovf = 0;
    for (int i = 0; i < N; i++) begin
      s = m[i] + ((en && !frz) ? 64'(inc[i*IW +: IW]) : 64'd0);
      if (clr) nm[i] = 64'd0;
      else if (we && wo == 14'(i)) nm[i] = {m[i][63:32], wd};
      else if (we && wo == 14'(64 + i)) nm[i] = ((64'(wd) << 32) | {32'd0, m[i][31:0]}) & MASK;
      else begin
        nm[i] = s & MASK;
        ovf[i] = s[W];
      end
    end
    if (clr) begin shv = 0; sh = 0; shi = 0; end
    else if (re && ro < N) begin sh = m[ro] >> 32; shi = ro; shv = 1; end
    if (IRQ) st = clr ? 32'd0 : ((st & ~((we && wo == 14'h3E) ? wd : 32'd0)) | ovf) & NMASK;
    if (we && wo == 14'h3F) begin en = wd[0]; frz = wd[1]; ie = IRQ && wd[3]; end
    if (re) begin exp_rd = r[31:0]; exp_hit = r[32]; end
    @(posedge clk);
    for (int i = 0; i < N; i++) m[i] = nm[i];
    #1;
    bus.csr_we = 0; bus.csr_re = 0; ev = '0;
    chk("irq", {63'd0, pmu_irq}, {63'd0, irq_n});
    chk("rdata", {32'd0, bus.csr_rdata}, {32'd0, exp_rd});
    chk("rhit", {63'd0, bus.csr_rhit}, {63'd0, exp_hit});
  endtask

  task automatic wr(logic [13:0] o, logic [31:0] d);
    cyc(1, B + o, d, 0, 14'd0, '0);
  endtask

  task automatic rd(string tag, logic [13:0] a, logic [31:0] e, bit h);
    cyc(0, 14'd0, 32'd0, 1, a, '0);
    chk(tag, {32'd0, bus.csr_rdata}, {32'd0, e});
    chk({tag, "_hit"}, {63'd0, bus.csr_rhit}, {63'd0, h});
  endtask

  function automatic logic [N*IW-1:0] one(int ch, int v);
    logic [N*IW-1:0] x;
    x = '0;
    x[ch*IW +: IW] = IW'(v);
    return x;
  endfunction

  function automatic logic [13:0] pick();
    int c;
    c = $urandom_range(9);
    if (c < 4) return B + 14'($urandom_range(N - 1));
    if (c < 7) return B + 14'(64 + $urandom_range(N - 1));
    if (c == 7) return B + 14'h3E;
    if (c == 8) return B + 14'h3F;
    return 14'($urandom);
  endfunction

  initial begin
    logic [N*IW-1:0] iv;
    logic [13:0] wa, ra;
    logic [31:0] wd;
    int wo;
    bit we, re;
    mreset();
    bus.csr_we = 0; bus.csr_waddr = 0; bus.csr_wdata = 0;
    bus.csr_re = 0; bus.csr_raddr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", {32'd0, bus.csr_rdata}, 64'd0);
    chk("rst_rhit", {63'd0, bus.csr_rhit}, 64'd0);
    chk("rst_irq", {63'd0, pmu_irq}, 64'd0);
    rst_n = 1;
    rd("rst_ctrl", B + 14'h3F, 32'h1, 1);
    rd("rst_cnt0", B, 32'h0, 1);

    repeat (5) cyc(0, 0, 0, 0, 0, one(0, 2));
    rd("count10", B, 32'd10, 1);
    wr(14'h3F, 32'h3);
    repeat (3) cyc(0, 0, 0, 0, 0, one(0, 2));
    rd("frozen10", B, 32'd10, 1);
    wr(14'h3F, 32'h1);

    wr(14'h40, 32'h0000FFFF);
    wr(14'h00, 32'hFFFFFFFE);
    cyc(0, 0, 0, 0, 0, one(0, 3));
    rd("wrap_lo", B, 32'd1, 1);
    rd("wrap_hi", B + 14'h40, 32'd0, 1);
    rd("wrap_status", B + 14'h3E, 32'(IRQ), 1);
    wr(14'h3F, 32'h9);
    cyc(0, 0, 0, 0, 0, '0);
    chk("irq_set", {63'd0, pmu_irq}, {63'd0, IRQ});
    wr(14'h3E, 32'h1);
    cyc(0, 0, 0, 0, 0, '0);
    chk("irq_clr", {63'd0, pmu_irq}, 64'd0);

    wr(14'h43, 32'h0000FFFF);
    wr(14'h03, 32'hFFFFFFFF);
    cyc(0, 0, 0, 0, 0, one(3, 1));
    wr(14'h43, 32'h0000FFFF);
    wr(14'h03, 32'hFFFFFFFF);
    cyc(1, B + 14'h3E, 32'h8, 0, 0, one(3, 1));
    rd("w1c_vs_ovf", B + 14'h3E, IRQ ? 32'h8 : 32'h0, 1);

    wr(14'h41, 32'h1);
    wr(14'h01, 32'hFFFFFFFF);
    rd("snap_lo", B + 14'h01, 32'hFFFFFFFF, 1);
    cyc(0, 0, 0, 0, 0, one(1, 1));
    rd("snap_hi", B + 14'h41, 32'd1, 1);
    wr(14'h44, 32'h1234);
    rd("live_hi", B + 14'h44, 32'h1234, 1);
    rd("snap_lo2", B + 14'h01, 32'd0, 1);
    rd("snap_hi2", B + 14'h41, 32'd2, 1);

    cyc(1, B + 14'h02, 32'd7, 0, 0, one(2, 1));
    rd("wr_wins", B + 14'h02, 32'd7, 1);
    iv = '0;
    for (int j = 0; j < N; j++) iv[j*IW +: IW] = IW'(3);
    cyc(1, B + 14'h3F, 32'h5, 0, 0, iv);
    for (int j = 0; j < N; j++) rd("clr_cnt", B + 14'(j), 32'd0, 1);
    rd("clr_ctrl", B + 14'h3F, 32'h1, 1);
    rd("clr_status", B + 14'h3E, 32'h0, 1);

    rd("miss_250", B + 14'h250, 32'd0, 0);
    rd("miss_lo", B + 14'(N), 32'd0, 0);
    rd("miss_hi", B + 14'(64 + N), 32'd0, 0);
    rd("miss_below", B - 14'd1, 32'd0, 0);

    for (int k = 0; k < 500; k++) begin
      we = ($urandom_range(3) == 0);
      re = $urandom_range(1) == 1;
      wa = pick();
      ra = pick();
      wd = $urandom;
      wo = int'(14'(wa - B));
      if (wo == 'h3F) wd = {28'd0, 1'($urandom), 1'($urandom_range(7) == 0), 1'($urandom_range(3) == 0), 1'($urandom_range(7) != 0)};
      else if (wo >= 64 && wo < 64 + N) wd = $urandom_range(1) ? 32'h0000FFFF : $urandom;
      else if (wo < N) wd = 32'hFFFFFFF0 | 32'($urandom_range(15));
      for (int j = 0; j < N; j++) iv[j*IW +: IW] = IW'($urandom);
      cyc(we, wa, wd, re, ra, iv);
    end

    wr(14'h3F, 32'h9);
    wr(14'h40, 32'h0000FFFF);
    wr(14'h00, 32'hFFFFFFFF);
    cyc(0, 0, 0, 0, 0, one(0, 1));
    cyc(0, 0, 0, 0, 0, '0);
    rd("pre_rst_ctrl", B + 14'h3F, IRQ ? 32'h9 : 32'h1, 1);
    #3;
    rst_n = 0;
    #1;
    chk("arst_rdata", {32'd0, bus.csr_rdata}, 64'd0);
    chk("arst_rhit", {63'd0, bus.csr_rhit}, 64'd0);
    chk("arst_irq", {63'd0, pmu_irq}, 64'd0);
    mreset();
    @(posedge clk);
    #1;
    rst_n = 1;
    rd("arst_ctrl", B + 14'h3F, 32'h1, 1);
    rd("arst_cnt", B + 14'h40, 32'h0, 1);
    rd("arst_status", B + 14'h3E, 32'h0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
